// File: rtl/seg_display_pkg.sv
// Shared definitions for the seven-segment scanner.
// Contents:
//   - Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
//   - The all-off anode pattern.
//   - Helpers that size the slot divider from the clock and refresh rates.
package seg_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF    = 4'hF;

    // Clocks per digit slot.
    function automatic int calc_div(input int clk_freq, input int refresh_hz);
        return clk_freq / refresh_hz;
    endfunction

    // Width of a counter that spans 0..div-1.
    function automatic int calc_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder.
// Output is active-low, {g,f,e,d,c,b,a}.
// Ports:
//   bcd_i  in  4 : BCD nibble. Values 10-15 are invalid and show a dash.
//   seg_o  out 7 : segment pattern.
module bcd_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed driver for a four-digit common-anode seven-segment display.
// Shows a packed-BCD {tens, ones} reading on the two rightmost digits.
// The reading is sampled once per four-slot frame, so both digits always come
// from the same sample.
// Ports:
//   clk           in  1 : system clock
//   init_regs_n   in  1 : synchronous active-low reset
//   time_reading  in  8 : [7:4] tens BCD, [3:0] ones BCD
//   seg           out 7 : {g,f,e,d,c,b,a}, active-low
//   dp            out 1 : decimal point, active-low, held off
//   an            out 4 : digit anodes, active-low, an[0] is the rightmost digit
module seg_display_scanner
    import seg_display_pkg::*;
#(
    parameter int CLK_FREQ      = 100000000,
    parameter int REFRESH_HZ    = 4000,
    parameter int BLANK_CYCLES  = 100,
    parameter int BLANK_LEADING = 1
) (
    input  logic       clk,
    input  logic       init_regs_n,
    input  logic [7:0] time_reading,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int               DIV       = calc_div(CLK_FREQ, REFRESH_HZ);
    localparam int               CNT_W     = calc_cnt_w(DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [7:0]       snap_q, snap_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q;

    logic             wrap;
    logic [3:0]       digit;
    logic [6:0]       dec_seg;
    logic             dark;

    bcd_to_seg u_dec (
        .bcd_i (digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        wrap      = (div_cnt_q == DIV_LAST);
        div_cnt_d = wrap ? '0 : div_cnt_q + CNT_W'(1);
        slot_d    = wrap ? slot_q + 2'd1 : slot_q;
        // The frame boundary is the last cycle of slot 3. The new slot 0 that
        // starts on the same edge already uses the fresh sample.
        snap_d    = (wrap && slot_q == 2'd3) ? time_reading : snap_q;

        digit = slot_q[0] ? snap_q[7:4] : snap_q[3:0];
        // Slots 2/3 are always dark. A zero tens digit may be dark too; an
        // invalid tens nibble is non-zero, so it still shows the dash.
        dark  = slot_q[1]
             || (slot_q[0] && (BLANK_LEADING != 0) && (snap_q[7:4] == 4'd0));

        // Segments may settle while the anodes are still off in the dead time.
        seg_d = dark ? SEG_BLANK : dec_seg;
        an_d  = (dark || (div_cnt_q < BLANK_END)) ? AN_OFF
                                                  : ~(4'b0001 << slot_q);
    end

    always_ff @(posedge clk) begin
        if (!init_regs_n) begin
            div_cnt_q <= '0;
            slot_q    <= 2'd0;
            snap_q    <= 8'h00;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
            dp_q      <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            slot_q    <= slot_d;
            snap_q    <= snap_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= 1'b1;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner.
// Two instances share all inputs:
//   - dut_a has leading-zero blanking on.
//   - dut_b has it off.
// Checking is done two ways:
//   - A cycle-count reference model pushes the expected outputs on every
//     posedge. The checker pops and compares them on the following negedge.
//   - The directed sequence also checks fixed values from the test plan.
module tb_seg_display_scanner;

    logic       clk = 1'b0;
    logic       init_regs_n;
    logic [7:0] time_reading;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic       dp_a, dp_b;

    int n_pass  = 0;
    int n_total = 0;
    int k       = 0;

    typedef struct packed {
        logic [3:0] an_a;
        logic [6:0] seg_a;
        logic [3:0] an_b;
        logic [6:0] seg_b;
    } exp_t;

    exp_t sbq[$];
    int   m_t    = 0;
    logic [7:0] m_snap = 8'h00;

    always #5 clk = ~clk;

    seg_display_scanner #(.CLK_FREQ(400), .REFRESH_HZ(100), .BLANK_CYCLES(1),
                          .BLANK_LEADING(1)) dut_a (
        .clk(clk), .init_regs_n(init_regs_n), .time_reading(time_reading),
        .seg(seg_a), .dp(dp_a), .an(an_a));

    seg_display_scanner #(.CLK_FREQ(400), .REFRESH_HZ(100), .BLANK_CYCLES(1),
                          .BLANK_LEADING(0)) dut_b (
        .clk(clk), .init_regs_n(init_regs_n), .time_reading(time_reading),
        .seg(seg_b), .dp(dp_b), .an(an_b));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [6:0] ref_dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h3F;
        endcase
    endfunction

    // t is the position within the 16-clock frame.
    function automatic logic ref_dark(input int t, input logic [7:0] s, input bit bl);
        int slot;
        slot = t / 4;
        return (slot >= 2) || (slot == 1 && bl && s[7:4] == 4'd0);
    endfunction

    function automatic logic [3:0] ref_an(input int t, input logic [7:0] s, input bit bl);
        if ((t % 4) < 1 || ref_dark(t, s, bl)) return 4'hF;
        return (t / 4 == 0) ? 4'hE : 4'hD;
    endfunction

    function automatic logic [6:0] ref_seg(input int t, input logic [7:0] s, input bit bl);
        if (ref_dark(t, s, bl)) return 7'h7F;
        return (t / 4 == 0) ? ref_dec(s[3:0]) : ref_dec(s[7:4]);
    endfunction

    // Reference model. Outputs after an edge reflect the pre-edge position.
    always @(posedge clk) begin
        exp_t e;
        if (!init_regs_n) begin
            e = '{an_a: 4'hF, seg_a: 7'h7F, an_b: 4'hF, seg_b: 7'h7F};
            m_t    <= 0;
            m_snap <= 8'h00;
        end else begin
            e.an_a  = ref_an(m_t, m_snap, 1'b1);
            e.seg_a = ref_seg(m_t, m_snap, 1'b1);
            e.an_b  = ref_an(m_t, m_snap, 1'b0);
            e.seg_b = ref_seg(m_t, m_snap, 1'b0);
            if (m_t == 15) m_snap <= time_reading;
            m_t <= (m_t + 1) % 16;
        end
        sbq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_an_a",  8'(an_a),  8'(e.an_a));
            chk("sb_seg_a", 8'(seg_a), 8'(e.seg_a));
            chk("sb_an_b",  8'(an_b),  8'(e.an_b));
            chk("sb_seg_b", 8'(seg_b), 8'(e.seg_b));
            chk("dp_off",   8'({dp_a, dp_b}), 8'h03);
            chk("an_one_low", 8'({$countones(~an_a) <= 1, $countones(~an_b) <= 1}), 8'h03);
        end
    end

    // Advance to the k-th negedge after reset release.
    task automatic go(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        init_regs_n  = 1'b0;
        time_reading = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_an",  8'(an_a),  8'h0F);
        chk("rst_seg", 8'(seg_a), 8'h7F);
        chk("rst_dp",  8'(dp_a),  8'h01);
        init_regs_n = 1'b1;
        k = 0;

        // First frame after reset: snapshot 00.
        go(1);  chk("f1_blank_an", 8'(an_a), 8'h0F);
        go(2);  chk("f1_s0_an", 8'(an_a), 8'h0E); chk("f1_s0_seg", 8'(seg_a), 8'h40);
        go(6);  chk("f1_s1_dark", 8'(an_a), 8'h0F);
        time_reading = 8'h47;

        // Frame 2 shows 4/7.
        go(17); chk("f2_s0_blank", 8'(an_a), 8'h0F);
        go(18); chk("f2_s0_an", 8'(an_a), 8'h0E); chk("f2_s0_seg", 8'(seg_a), 8'h78);
        go(21); chk("f2_s1_blank", 8'(an_a), 8'h0F);
        go(22); chk("f2_s1_an", 8'(an_a), 8'h0D); chk("f2_s1_seg", 8'(seg_a), 8'h19);
        go(26); chk("f2_s2_an", 8'(an_a), 8'h0F);
        go(30); chk("f2_s3_an", 8'(an_a), 8'h0F);
        time_reading = 8'h19;

        // Frame 3 shows 1/9. A change mid-slot-1 must not tear it.
        go(34); chk("f3_s0_seg", 8'(seg_a), 8'h10);
        go(38); chk("f3_s1_seg", 8'(seg_a), 8'h79);
        time_reading = 8'h20;
        go(39); chk("tear_s1_seg", 8'(seg_a), 8'h79); chk("tear_s1_an", 8'(an_a), 8'h0D);
        go(50); chk("f4_s0_seg", 8'(seg_a), 8'h40);
        go(54); chk("f4_s1_seg", 8'(seg_a), 8'h24);
        time_reading = 8'h05;

        // Leading zero: dut_a blanks tens, dut_b shows 0.
        go(66); chk("lz_s0_seg", 8'(seg_a), 8'h12); chk("lz_s0_seg_b", 8'(seg_b), 8'h12);
        go(70); chk("lz_a_an", 8'(an_a), 8'h0F);
                chk("lz_b_an", 8'(an_b), 8'h0D); chk("lz_b_seg", 8'(seg_b), 8'h40);
        time_reading = 8'hA3;

        // Invalid tens nibble shows a dash and stays lit.
        go(82); chk("inv_s0_seg", 8'(seg_a), 8'h30);
        go(86); chk("inv_s1_seg", 8'(seg_a), 8'h3F); chk("inv_s1_an", 8'(an_a), 8'h0D);
        time_reading = 8'h99;

        // Reset during slot 1 while 9/9 is displayed.
        go(102); chk("pre_rst_seg", 8'(seg_a), 8'h10); chk("pre_rst_an", 8'(an_a), 8'h0D);
        init_regs_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_an", 8'(an_a), 8'h0F); chk("mid_rst_seg", 8'(seg_a), 8'h7F);
        init_regs_n = 1'b1;
        k = 0;
        go(2);  chk("rr_s0_an", 8'(an_a), 8'h0E); chk("rr_s0_seg", 8'(seg_a), 8'h40);
        go(6);  chk("rr_s1_dark", 8'(an_a), 8'h0F); chk("rr_s1_seg_b", 8'(seg_b), 8'h40);
        go(18); chk("rr_f2_s0_seg", 8'(seg_a), 8'h10);
        go(22); chk("rr_f2_s1_seg", 8'(seg_a), 8'h10); chk("rr_f2_s1_an", 8'(an_a), 8'h0D);
        go(24);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
